// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param
// Description : Parameterised single-clock show-ahead FIFO. It supports any
//               data width, any depth of 2 or more (including
//               non-power-of-two), programmable almost-full and almost-empty
//               thresholds, and a selectable write-while-full policy
//               (overwrite the oldest entry, or drop the write).
//               rdata always presents the oldest stored entry.
//               Optional macro FIFO_ERR_FLAGS_EN builds sticky
//               overflow/underflow flags that are cleared by err_clr.
// Ports       : clk, rst (sync, active-high)
//               wen/wdata  - write request and data
//               ren        - pop the entry shown on rdata
//               rdata      - oldest entry (combinational read)
//               count      - number of stored entries, 0..DEPTH
//               full/empty/almost_full/almost_empty - status from count
//               err_clr    - clear sticky error flags
//               overflow/underflow - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_param #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter bit OVERWRITE     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wen,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          ren,
    output logic [WIDTH-1:0]              rdata,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    input  logic                          err_clr,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] c_PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] c_AFULL    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] c_AEMPTY   = CW'(AEMPTY_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_waddr;
    logic [AW-1:0]    r_raddr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_we;
    logic w_re;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths never
    // address past the end of the array.
    function automatic logic [AW-1:0] f_ptr_inc(input logic [AW-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // A write while full is accepted when a pop frees a slot in the same
    // cycle, or when the overwrite policy lets it displace the oldest entry.
    assign w_we = wen && (!w_full || ren || OVERWRITE);
    assign w_re = ren && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_waddr <= '0;
            r_raddr <= '0;
            r_count <= '0;
        end else begin
            if (w_we) begin
                r_waddr <= f_ptr_inc(r_waddr);
            end
            // An overwrite while full also retires the oldest entry.
            if (w_re || (w_we && w_full)) begin
                r_raddr <= f_ptr_inc(r_raddr);
            end
            if (w_we && !w_re && !w_full) begin
                r_count <= r_count + CW'(1);
            end else if (w_re && !w_we) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage has no reset; contents are only meaningful while count > 0.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_waddr] <= wdata;
        end
    end

    assign rdata        = r_mem[r_raddr];
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AFULL);
    assign almost_empty = (r_count <= c_AEMPTY);

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // err_clr wins over a set arriving on the same edge.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wen && w_full && !ren) begin
                r_overflow <= 1'b1;
            end
            if (ren && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

`ifdef FORMAL
    int w_ptr_diff;
    assign w_ptr_diff = (int'(r_waddr) - int'(r_raddr) + DEPTH) % DEPTH;

    always_comb begin
        if (!rst) begin
            assert (!(w_full && w_empty));
            assert (r_count <= c_DEPTH);
            assert ((int'(r_count) == w_ptr_diff) ||
                    ((w_ptr_diff == 0) && (r_count == c_DEPTH)));
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        (r_count == $past(r_count)) ||
        (r_count == $past(r_count) + CW'(1)) ||
        (r_count + CW'(1) == $past(r_count)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_param
// Description : Directed self-checking bench for fifo_param. Two DEPTH=5,
//               WIDTH=12 instances share the same stimulus: u_ow uses the
//               overwrite-oldest policy and u_dr uses the drop policy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_param;

    localparam int W  = 12;
    localparam int D  = 5;
    localparam int CW = $clog2(D + 1);

`ifdef FIFO_ERR_FLAGS_EN
    localparam bit c_EF = 1'b1;
`else
    localparam bit c_EF = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          wen;
    logic          ren;
    logic          err_clr;
    logic [W-1:0]  wdata;

    logic [W-1:0]  a_rdata, b_rdata;
    logic [CW-1:0] a_count, b_count;
    logic          a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic          b_full, b_empty, b_af, b_ae, b_ovf, b_unf;

    int checks = 0;
    int errors = 0;

    fifo_param #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b1)) u_ow (
        .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(a_rdata), .count(a_count), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .err_clr(err_clr),
        .overflow(a_ovf), .underflow(a_unf)
    );

    fifo_param #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b0)) u_dr (
        .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(b_rdata), .count(b_count), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .err_clr(err_clr),
        .overflow(b_ovf), .underflow(b_unf)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base);
        for (int i = 1; i <= D; i++) begin
            wen = 1'b1; wdata = W'(base + i);
            tick();
        end
        wen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wen = 1'b1; ren = 1'b1; wdata = 12'hFFF;
        tick();
        rst = 1'b0; wen = 1'b0; ren = 1'b0;
        tick();
        checks++;
        if (a_count !== 3'd0 || b_count !== 3'd0) begin
            errors++; $display("FAIL reset_count got %0d/%0d exp 0", a_count, b_count);
        end
        checks++;
        if ({a_full, a_empty, a_af, a_ae} !== 4'b0101) begin
            errors++; $display("FAIL reset_flags got %b exp 0101", {a_full, a_empty, a_af, a_ae});
        end
        checks++;
        if ({a_ovf, a_unf, b_ovf, b_unf} !== 4'b0000) begin
            errors++; $display("FAIL reset_err got %b exp 0000", {a_ovf, a_unf, b_ovf, b_unf});
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= D; i++) begin
            wen = 1'b1; wdata = W'(i);
            tick();
            checks++;
            if (a_count !== CW'(i) || b_count !== CW'(i)) begin
                errors++; $display("FAIL fill_count i=%0d got %0d/%0d exp %0d", i, a_count, b_count, i);
            end
            checks++;
            if ({a_full, a_empty, a_af, a_ae} !== {i == D, 1'b0, i >= 3, i <= 2}) begin
                errors++; $display("FAIL fill_flags i=%0d got %b exp %b", i,
                                   {a_full, a_empty, a_af, a_ae}, {i == D, 1'b0, i >= 3, i <= 2});
            end
        end
        wen = 1'b0;
        for (int i = 1; i <= D; i++) begin
            checks++;
            if (a_rdata !== W'(i) || b_rdata !== W'(i)) begin
                errors++; $display("FAIL drain_data i=%0d got %h/%h exp %h", i, a_rdata, b_rdata, W'(i));
            end
            ren = 1'b1;
            tick();
            ren = 1'b0;
            checks++;
            if (a_count !== CW'(D - i)) begin
                errors++; $display("FAIL drain_count i=%0d got %0d exp %0d", i, a_count, D - i);
            end
        end
        checks++;
        if ({a_full, a_empty, a_af, a_ae} !== 4'b0101) begin
            errors++; $display("FAIL drain_flags got %b exp 0101", {a_full, a_empty, a_af, a_ae});
        end
    endtask

    task automatic test_overwrite();
        fill(0);
        wen = 1'b1; wdata = 12'd6;
        tick();
        wen = 1'b0;
        checks++;
        if (a_count !== 3'd5 || b_count !== 3'd5 || a_full !== 1'b1 || b_full !== 1'b1) begin
            errors++; $display("FAIL ovw_count got %0d/%0d exp 5", a_count, b_count);
        end
        checks++;
        if (a_ovf !== c_EF || b_ovf !== c_EF) begin
            errors++; $display("FAIL ovw_overflow got %b/%b exp %b", a_ovf, b_ovf, c_EF);
        end
        for (int i = 0; i < D; i++) begin
            checks++;
            if (a_rdata !== W'(i + 2) || b_rdata !== W'(i + 1)) begin
                errors++; $display("FAIL ovw_data i=%0d got %h/%h exp %h/%h", i, a_rdata, b_rdata,
                                   W'(i + 2), W'(i + 1));
            end
            ren = 1'b1;
            tick();
            ren = 1'b0;
        end
        checks++;
        if (a_empty !== 1'b1 || b_empty !== 1'b1 || a_ovf !== c_EF) begin
            errors++; $display("FAIL ovw_end got empty %b/%b ovf %b exp 1/1 %b", a_empty, b_empty, a_ovf, c_EF);
        end
    endtask

    task automatic test_empty_read();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (a_ovf !== 1'b0 || b_ovf !== 1'b0) begin
            errors++; $display("FAIL errclr_ovf got %b/%b exp 0", a_ovf, b_ovf);
        end
        ren = 1'b1;
        tick();
        ren = 1'b0;
        checks++;
        if (a_count !== 3'd0 || a_empty !== 1'b1 || a_unf !== c_EF || b_unf !== c_EF) begin
            errors++; $display("FAIL empty_read got cnt %0d emp %b unf %b/%b exp 0 1 %b",
                               a_count, a_empty, a_unf, b_unf, c_EF);
        end
        wen = 1'b1; ren = 1'b1; wdata = 12'h0AB;
        tick();
        wen = 1'b0; ren = 1'b0;
        checks++;
        if (a_count !== 3'd1 || b_count !== 3'd1 || a_rdata !== 12'h0AB || b_rdata !== 12'h0AB) begin
            errors++; $display("FAIL empty_wr_rd got cnt %0d/%0d data %h/%h exp 1 0ab",
                               a_count, b_count, a_rdata, b_rdata);
        end
        ren = 1'b1;
        tick();
        // The FIFO is empty again here: err_clr must win over the underflow set.
        err_clr = 1'b1;
        tick();
        ren = 1'b0; err_clr = 1'b0;
        checks++;
        if (a_unf !== 1'b0 || b_unf !== 1'b0 || a_count !== 3'd0) begin
            errors++; $display("FAIL errclr_prio got unf %b/%b cnt %0d exp 0 0", a_unf, b_unf, a_count);
        end
    endtask

    task automatic test_back_to_back();
        fill(12'h100);
        for (int k = 0; k < 10; k++) begin
            wen = 1'b1; ren = 1'b1; wdata = W'(12'h106 + k);
            checks++;
            if (a_rdata !== W'(12'h101 + k) || b_rdata !== W'(12'h101 + k)) begin
                errors++; $display("FAIL b2b_data k=%0d got %h/%h exp %h", k, a_rdata, b_rdata, W'(12'h101 + k));
            end
            tick();
            checks++;
            if (a_count !== 3'd5 || b_count !== 3'd5 || a_full !== 1'b1 || b_full !== 1'b1) begin
                errors++; $display("FAIL b2b_count k=%0d got %0d/%0d exp 5", k, a_count, b_count);
            end
        end
        wen = 1'b0; ren = 1'b0;
        checks++;
        if (a_rdata !== 12'h10B || b_rdata !== 12'h10B || a_ovf !== 1'b0) begin
            errors++; $display("FAIL b2b_tail got %h/%h ovf %b exp 10b 0", a_rdata, b_rdata, a_ovf);
        end
        rst = 1'b1; wen = 1'b1; wdata = 12'hEEE;
        tick();
        rst = 1'b0; wen = 1'b0;
        checks++;
        if (a_count !== 3'd0 || b_count !== 3'd0 || a_empty !== 1'b1 || b_empty !== 1'b1) begin
            errors++; $display("FAIL midrst got cnt %0d/%0d emp %b/%b exp 0 1", a_count, b_count, a_empty, b_empty);
        end
        wen = 1'b1; wdata = 12'h5A5;
        tick();
        wen = 1'b0;
        checks++;
        if (a_count !== 3'd1 || a_rdata !== 12'h5A5 || b_rdata !== 12'h5A5) begin
            errors++; $display("FAIL post_rst got cnt %0d data %h/%h exp 1 5a5", a_count, a_rdata, b_rdata);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; wen = 1'b0; ren = 1'b0; err_clr = 1'b0; wdata = '0;
        test_reset();
        test_fill_drain();
        test_overwrite();
        test_empty_read();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
